// File: rtl/lexer_pkg.sv
// Shared encodings for the lexer sequencer: FSM states, lexer step codes
// and the token kind codes carried in bits [7:0] of a lexer token.
`timescale 1ns/1ps
package lexer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_STEP    = 3'd1,
    ST_WAIT    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_FLUSH   = 3'd4,
    ST_DONE    = 3'd5
  } seq_state_t;

  localparam logic [7:0]  LEX_STEP_GO   = 8'd1;
  localparam logic [7:0]  LEX_STEP_HOLD = 8'd0;

  localparam logic [31:0] TOK_NONE      = 32'd0;

  // Kinds below 8 are structural codes; 8 and above are literal characters.
  localparam logic [7:0]  TOK_NUL       = 8'd0;
  localparam logic [7:0]  TOK_IDENT     = 8'd1;
  localparam logic [7:0]  TOK_NUMBER    = 8'd2;
  localparam logic [7:0]  TOK_EQUALS    = 8'd3;
  localparam logic [7:0]  TOK_LAMBDA    = 8'd4;
  localparam logic [7:0]  TOK_DOT       = 8'd5;
  localparam logic [7:0]  TOK_LPAREN    = 8'd6;
  localparam logic [7:0]  TOK_RPAREN    = 8'd7;

endpackage

// File: rtl/token_fifo.sv
// First-word-fall-through token FIFO: the head word is visible on dout
// whenever the FIFO is non-empty, and pop consumes it.
`timescale 1ns/1ps
module token_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk_25mhz,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A push into a full FIFO only lands if the head leaves in the same clock.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk_25mhz or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (!do_push && do_pop) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_25mhz) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/lexer_sequencer.sv
// Feeds source bytes to the lexer one step at a time, captures emitted tokens
// into a FWFT FIFO, and flushes the lexer with NUL bytes after the last byte.
`timescale 1ns/1ps
module lexer_sequencer
  import lexer_pkg::*;
#(
  parameter int FIFO_DEPTH  = 16,
  parameter int LEX_LATENCY = 2,
  parameter int FLUSH_STEPS = 4
) (
  input  logic        clk_25mhz,
  input  logic        reset,
  input  logic [7:0]  src_data,
  input  logic        src_valid,
  output logic        src_ready,
  input  logic        src_last,
  output logic [7:0]  lex_data_in,
  output logic [7:0]  lex_step,
  input  logic [31:0] lex_data_out,
  output logic [31:0] tok_data,
  output logic        tok_valid,
  input  logic        tok_pop,
  output logic        busy,
  output logic        done
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int WW = (LEX_LATENCY > 1) ? $clog2(LEX_LATENCY) : 1;
  localparam int FW = $clog2(FLUSH_STEPS + 1);

  seq_state_t     state_q, state_d;
  logic [7:0]     lex_data_q, lex_data_d;
  logic           last_q, last_d;
  logic           flushing_q, flushing_d;
  logic [WW-1:0]  wait_cnt_q, wait_cnt_d;
  logic [FW-1:0]  flush_cnt_q, flush_cnt_d;

  logic [CW-1:0]  fifo_count;
  logic           fifo_empty;
  logic           fifo_full;
  logic           fifo_push;

  always_ff @(posedge clk_25mhz or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      lex_data_q  <= 8'd0;
      last_q      <= 1'b0;
      flushing_q  <= 1'b0;
      wait_cnt_q  <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      lex_data_q  <= lex_data_d;
      last_q      <= last_d;
      flushing_q  <= flushing_d;
      wait_cnt_q  <= wait_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    lex_data_d  = lex_data_q;
    last_d      = last_q;
    flushing_d  = flushing_q;
    wait_cnt_d  = wait_cnt_q;
    flush_cnt_d = flush_cnt_q;
    src_ready   = 1'b0;
    lex_step    = LEX_STEP_HOLD;
    fifo_push   = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        // Accepting only with a free slot guarantees room for this byte's token.
        src_ready = !reset && (fifo_count <= CW'(FIFO_DEPTH - 1));
        if (src_valid && src_ready) begin
          lex_data_d = src_data;
          last_d     = src_last;
          flushing_d = 1'b0;
          state_d    = ST_STEP;
        end
      end
      ST_STEP: begin
        lex_step   = LEX_STEP_GO;
        wait_cnt_d = WW'(LEX_LATENCY - 1);
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        // CAPTURE lands LEX_LATENCY clocks after the step pulse.
        wait_cnt_d = (wait_cnt_q == '0) ? '0 : wait_cnt_q - 1'b1;
        if (wait_cnt_q <= WW'(1)) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        fifo_push = (lex_data_out != TOK_NONE);
        if (flushing_q && flush_cnt_q == '0) begin
          state_d = ST_DONE;
        end else if (flushing_q) begin
          state_d = ST_FLUSH;
        end else if (last_q) begin
          flush_cnt_d = FW'(FLUSH_STEPS);
          flushing_d  = 1'b1;
          state_d     = ST_FLUSH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        if (!fifo_full) begin
          lex_data_d  = 8'd0;
          flush_cnt_d = flush_cnt_q - 1'b1;
          state_d     = ST_STEP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  token_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_token_fifo (
    .clk_25mhz (clk_25mhz),
    .reset     (reset),
    .push      (fifo_push),
    .din       (lex_data_out),
    .pop       (tok_pop),
    .dout      (tok_data),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign lex_data_in = lex_data_q;
  assign tok_valid   = !fifo_empty;
  assign busy        = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done        = (state_q == ST_DONE);

endmodule

// File: tb/tb_lexer_sequencer.sv
// Randomized bench for lexer_sequencer with a behavioural lexer and a
// string-level reference model of the step and token sequences.
`timescale 1ns/1ps
module tb_lexer_sequencer;

  localparam int DEPTH = 4;
  localparam int LAT   = 2;
  localparam int FLUSH = 4;

  logic        clk_25mhz = 1'b0;
  logic        reset     = 1'b1;
  logic [7:0]  src_data  = 8'd0;
  logic        src_valid = 1'b0;
  logic        src_last  = 1'b0;
  logic        tok_pop   = 1'b0;
  logic        src_ready;
  logic [7:0]  lex_data_in;
  logic [7:0]  lex_step;
  logic [31:0] lex_data_out;
  logic [31:0] tok_data;
  logic        tok_valid;
  logic        busy;
  logic        done;

  always #20 clk_25mhz = ~clk_25mhz;

  lexer_sequencer #(
    .FIFO_DEPTH  (DEPTH),
    .LEX_LATENCY (LAT),
    .FLUSH_STEPS (FLUSH)
  ) dut (
    .clk_25mhz    (clk_25mhz),
    .reset        (reset),
    .src_data     (src_data),
    .src_valid    (src_valid),
    .src_ready    (src_ready),
    .src_last     (src_last),
    .lex_data_in  (lex_data_in),
    .lex_step     (lex_step),
    .lex_data_out (lex_data_out),
    .tok_data     (tok_data),
    .tok_valid    (tok_valid),
    .tok_pop      (tok_pop),
    .busy         (busy),
    .done         (done)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Lexer behaviour: 0 echo, 1 silent, 2 always emits, 3 hashed mix.
  function automatic logic [31:0] lex_fn(input int mode, input logic [7:0] b);
    logic [31:0] r;
    logic [15:0] h;
    h = 16'({8'd0, b} * 16'd37 + 16'd11);
    case (mode)
      0:       r = {24'd0, b};
      1:       r = 32'd0;
      2:       r = 32'hC000_0000 | {24'd0, b};
      default: r = (h[1:0] == 2'b00) ? 32'd0 : {h, 8'h00, b};
    endcase
    return r;
  endfunction

  int lex_mode = 0;
  logic [31:0] lat_q [LAT];

  always @(posedge clk_25mhz) begin
    if (reset) begin
      for (int k = 0; k < LAT; k++) lat_q[k] <= 32'd0;
    end else begin
      if (lex_step == 8'd1) lat_q[0] <= lex_fn(lex_mode, lex_data_in);
      for (int k = 1; k < LAT; k++) lat_q[k] <= lat_q[k-1];
    end
  end
  assign lex_data_out = lat_q[LAT-1];

  logic [7:0]  steps_q [$];
  logic [31:0] got_q [$];
  int cyc = 0, last_step = -1, min_gap = 1000;
  bit pop_en = 1'b0, pop_rand = 1'b0;

  initial forever begin
    @(negedge clk_25mhz);
    cyc++;
    if (reset) begin
      last_step = -1;
    end else if (lex_step != 8'd0) begin
      check("lex_step_val", {24'd0, lex_step}, 32'd1);
      steps_q.push_back(lex_data_in);
      if (last_step >= 0 && cyc - last_step < min_gap) min_gap = cyc - last_step;
      last_step = cyc;
    end
  end

  initial forever begin
    @(negedge clk_25mhz);
    if (!reset && pop_en && tok_valid && (!pop_rand || $urandom_range(0, 3) != 0)) begin
      got_q.push_back(tok_data);
      tok_pop = 1'b1;
    end else begin
      tok_pop = 1'b0;
    end
  end

  logic [7:0] str_q [$];

  task automatic send_byte(input logic [7:0] b, input logic last);
    int n = 0;
    src_data  = b;
    src_last  = last;
    src_valid = 1'b1;
    while (!src_ready && n < 400) begin
      @(negedge clk_25mhz);
      n++;
    end
    if (!src_ready) check("accept_timeout", 32'd0, 32'd1);
    else begin
      @(posedge clk_25mhz);
      #1;
    end
    src_valid = 1'b0;
    src_last  = 1'b0;
    @(negedge clk_25mhz);
  endtask

  task automatic feed_string();
    foreach (str_q[i]) send_byte(str_q[i], (i == str_q.size() - 1));
  endtask

  task automatic run_string(input int mode, input bit randpop, input bit stall_test);
    logic [7:0]  exp_steps [$];
    logic [31:0] exp_toks [$];
    int n;
    lex_mode = mode;
    pop_rand = randpop;
    pop_en   = !stall_test;
    steps_q.delete();
    got_q.delete();
    min_gap = 1000;
    foreach (str_q[i]) exp_steps.push_back(str_q[i]);
    for (int i = 0; i < FLUSH; i++) exp_steps.push_back(8'd0);
    foreach (exp_steps[i])
      if (lex_fn(mode, exp_steps[i]) != 32'd0) exp_toks.push_back(lex_fn(mode, exp_steps[i]));

    if (stall_test) begin
      fork
        feed_string();
        begin
          repeat (150) @(negedge clk_25mhz);
          check("stall_src_ready", {31'd0, src_ready}, 32'd0);
          check("stall_tok_valid", {31'd0, tok_valid}, 32'd1);
          check("stall_busy", {31'd0, busy}, 32'd0);
          check("stall_steps", steps_q.size(), DEPTH);
          pop_en = 1'b1;
        end
      join
    end else begin
      feed_string();
    end

    n = 0;
    while (!done && n < 500) begin
      @(negedge clk_25mhz);
      n++;
    end
    check("done", {31'd0, done}, 32'd1);
    check("busy_at_done", {31'd0, busy}, 32'd0);
    n = 0;
    while ((tok_valid || got_q.size() < exp_toks.size()) && n < 300) begin
      @(negedge clk_25mhz);
      n++;
    end
    repeat (2) @(negedge clk_25mhz);

    check("n_steps", steps_q.size(), exp_steps.size());
    for (int i = 0; i < exp_steps.size() && i < steps_q.size(); i++)
      check($sformatf("step[%0d]", i), {24'd0, steps_q[i]}, {24'd0, exp_steps[i]});
    check("n_tokens", got_q.size(), exp_toks.size());
    for (int i = 0; i < exp_toks.size() && i < got_q.size(); i++)
      check($sformatf("tok[%0d]", i), got_q[i], exp_toks[i]);
    check("min_gap_ok", {31'd0, (min_gap >= LAT + 2)}, 32'd1);
    $display("string len=%0d mode=%0d steps=%0d tokens=%0d min_gap=%0d", str_q.size(), mode,
             steps_q.size(), got_q.size(), min_gap);
  endtask

  task automatic load_str(input string s);
    str_q.delete();
    for (int i = 0; i < s.len(); i++) str_q.push_back(s[i]);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    #50;
    check("rst_lex_data_in", {24'd0, lex_data_in}, 32'd0);
    check("rst_lex_step", {24'd0, lex_step}, 32'd0);
    check("rst_src_ready", {31'd0, src_ready}, 32'd0);
    check("rst_tok_valid", {31'd0, tok_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    #50;
    @(negedge clk_25mhz);
    reset = 1'b0;
    #1;
    check("post_rst_src_ready", {31'd0, src_ready}, 32'd1);
    check("post_rst_tok_valid", {31'd0, tok_valid}, 32'd0);
    @(negedge clk_25mhz);

    str_q.delete();
    str_q.push_back(8'd120);
    run_string(0, 1'b0, 1'b0);

    load_str(" id=\\x.x");
    run_string(0, 1'b0, 1'b0);

    load_str("abcdef");
    run_string(2, 1'b0, 1'b1);

    // Reset while a step is in flight, with a token already buffered.
    pop_en = 1'b0;
    lex_mode = 0;
    send_byte(8'h61, 1'b0);
    n = 0;
    while (busy && n < 50) begin
      @(negedge clk_25mhz);
      n++;
    end
    check("pre_rst_tok_valid", {31'd0, tok_valid}, 32'd1);
    send_byte(8'h62, 1'b0);
    @(negedge clk_25mhz);
    check("wait_busy", {31'd0, busy}, 32'd1);
    #5 reset = 1'b1;
    #1;
    check("midrst_lex_step", {24'd0, lex_step}, 32'd0);
    check("midrst_tok_valid", {31'd0, tok_valid}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_src_ready", {31'd0, src_ready}, 32'd0);
    check("midrst_lex_data_in", {24'd0, lex_data_in}, 32'd0);
    repeat (3) @(negedge clk_25mhz);
    reset = 1'b0;
    repeat (4) @(negedge clk_25mhz);
    check("post_midrst_empty", {31'd0, tok_valid}, 32'd0);
    load_str("ok");
    run_string(0, 1'b0, 1'b0);

    str_q.delete();
    for (int i = 0; i < 5; i++) str_q.push_back(8'($urandom_range(1, 255)));
    run_string(1, 1'b0, 1'b0);

    for (int r = 0; r < 10; r++) begin
      str_q.delete();
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) str_q.push_back(8'($urandom_range(0, 255)));
      run_string((r % 2 == 0) ? 3 : 0, 1'b1, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
